// File: rtl/grom_io_ctrl.sv
// grom_io_ctrl: I/O-space responder for the grom CPU bus. Holds the display
// and LED registers, a debounced button port with sticky rising-edge flags,
// and a prescaled 16-bit timer with a coherent LO/HI read snapshot.
//
// Bus protocol: a cycle belongs to this block only while i_Ioreq=1. With
// i_We=1 the addressed register takes i_Data on that edge. With i_We=0 the
// read value appears on o_Data after that edge and holds until the next read.
// There is no stall or handshake; every I/O cycle completes in one clock.
module grom_io_ctrl #(
  parameter int PRESCALE = 1000,
  parameter int DEBOUNCE = 16,
  parameter int IO_AW    = 8
) (
  input  logic             i_Clk,
  input  logic             i_Reset_n,
  input  logic [IO_AW-1:0] i_Addr,
  input  logic [7:0]       i_Data,
  input  logic             i_We,
  input  logic             i_Ioreq,
  output logic [7:0]       o_Data,
  output logic [3:0]       o_Leds,
  output logic [7:0]       o_Display,
  input  logic [3:0]       i_Buttons
);

  localparam int PW = $clog2(PRESCALE);
  localparam int DW = $clog2(DEBOUNCE);

  localparam logic [PW-1:0] PRE_LAST = PW'(PRESCALE - 1);
  localparam logic [DW-1:0] DEB_LAST = DW'(DEBOUNCE - 1);

  localparam logic [IO_AW-1:0] ADDR_DISPLAY  = IO_AW'(0);
  localparam logic [IO_AW-1:0] ADDR_LED      = IO_AW'(1);
  localparam logic [IO_AW-1:0] ADDR_BTN      = IO_AW'(2);
  localparam logic [IO_AW-1:0] ADDR_BTN_EDGE = IO_AW'(3);
  localparam logic [IO_AW-1:0] ADDR_TMR_LO   = IO_AW'(4);
  localparam logic [IO_AW-1:0] ADDR_TMR_HI   = IO_AW'(5);
  localparam logic [IO_AW-1:0] ADDR_TMR_CTRL = IO_AW'(6);

  logic [3:0]    sync1_q, sync1_d, sync2_q, sync2_d;
  logic [3:0]    deb_q, deb_d, edge_q, edge_d;
  logic [DW-1:0] deb_cnt_q [4];
  logic [DW-1:0] deb_cnt_d [4];
  logic [7:0]    display_q, display_d;
  logic [3:0]    leds_q, leds_d;
  logic [7:0]    rdata_q, rdata_d;
  logic [7:0]    snap_q, snap_d;
  logic          en_q, en_d;
  logic [PW-1:0] pre_q, pre_d;
  logic [15:0]   timer_q, timer_d;

  logic          wr_cyc, rd_cyc, tick, clear, edge_clr;
  logic [3:0]    rise;

  assign wr_cyc = i_Ioreq & i_We;
  assign rd_cyc = i_Ioreq & ~i_We;

  // Button synchronizer and per-bit debounce counters; a rise sets its flag on the same edge
  always_comb begin
    sync1_d = i_Buttons;
    sync2_d = sync1_q;
    deb_d   = deb_q;
    for (int i = 0; i < 4; i++) begin
      deb_cnt_d[i] = '0;
      if (sync2_q[i] != deb_q[i]) begin
        if (deb_cnt_q[i] == DEB_LAST) begin
          deb_d[i] = sync2_q[i];
        end else begin
          deb_cnt_d[i] = deb_cnt_q[i] + DW'(1);
        end
      end
    end
    rise     = deb_d & ~deb_q;
    edge_clr = rd_cyc && (i_Addr == ADDR_BTN_EDGE);
    // A new edge wins over the read-to-clear of the same cycle.
    edge_d   = (edge_q & ~{4{edge_clr}}) | rise;
  end

  // Register writes, prescaled timer with clear-beats-tick, and registered read data
  always_comb begin
    display_d = display_q;
    leds_d    = leds_q;
    en_d      = en_q;
    pre_d     = pre_q;
    timer_d   = timer_q;
    snap_d    = snap_q;
    rdata_d   = rdata_q;
    clear     = 1'b0;
    tick      = en_q && (pre_q == PRE_LAST);

    if (en_q) begin
      pre_d = tick ? '0 : pre_q + PW'(1);
      if (tick) timer_d = timer_q + 16'd1;
    end

    if (wr_cyc) begin
      case (i_Addr)
        ADDR_DISPLAY:  display_d = i_Data;
        ADDR_LED:      leds_d    = i_Data[3:0];
        ADDR_TMR_CTRL: begin
          en_d  = i_Data[0];
          clear = i_Data[1];
        end
        default: ;
      endcase
    end

    if (clear) begin
      pre_d   = '0;
      timer_d = '0;
    end

    if (rd_cyc) begin
      case (i_Addr)
        ADDR_DISPLAY:  rdata_d = display_q;
        ADDR_LED:      rdata_d = {4'h0, leds_q};
        ADDR_BTN:      rdata_d = {4'h0, deb_q};
        ADDR_BTN_EDGE: rdata_d = {4'h0, edge_q};
        ADDR_TMR_LO: begin
          rdata_d = timer_q[7:0];
          snap_d  = timer_q[15:8];
        end
        ADDR_TMR_HI:   rdata_d = snap_q;
        ADDR_TMR_CTRL: rdata_d = {7'h00, en_q};
        default:       rdata_d = 8'h00;
      endcase
    end
  end

  // State registers; timer comes out of reset enabled
  always_ff @(posedge i_Clk or negedge i_Reset_n) begin
    if (!i_Reset_n) begin
      sync1_q   <= '0;
      sync2_q   <= '0;
      deb_q     <= '0;
      edge_q    <= '0;
      for (int i = 0; i < 4; i++) deb_cnt_q[i] <= '0;
      display_q <= '0;
      leds_q    <= '0;
      rdata_q   <= '0;
      snap_q    <= '0;
      en_q      <= 1'b1;
      pre_q     <= '0;
      timer_q   <= '0;
    end else begin
      sync1_q   <= sync1_d;
      sync2_q   <= sync2_d;
      deb_q     <= deb_d;
      edge_q    <= edge_d;
      for (int i = 0; i < 4; i++) deb_cnt_q[i] <= deb_cnt_d[i];
      display_q <= display_d;
      leds_q    <= leds_d;
      rdata_q   <= rdata_d;
      snap_q    <= snap_d;
      en_q      <= en_d;
      pre_q     <= pre_d;
      timer_q   <= timer_d;
    end
  end

  assign o_Data    = rdata_q;
  assign o_Leds    = leds_q;
  assign o_Display = display_q;

endmodule

// File: tb/tb_grom_io_ctrl.sv
// tb_grom_io_ctrl: directed and randomized checks of grom_io_ctrl against a
// cycle-level behavioural model of the register map, buttons and timer.
module tb_grom_io_ctrl;
  localparam int PRESCALE = 4;
  localparam int DEBOUNCE = 4;
  localparam int IO_AW    = 8;

  logic             clk;
  logic             rst_n;
  logic [IO_AW-1:0] addr;
  logic [7:0]       wdata;
  logic             we;
  logic             ioreq;
  logic [3:0]       buttons;
  logic [7:0]       o_data;
  logic [3:0]       o_leds;
  logic [7:0]       o_display;

  int    ntests = 0;
  int    nfail  = 0;
  string phase  = "init";

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  grom_io_ctrl #(
    .PRESCALE(PRESCALE),
    .DEBOUNCE(DEBOUNCE),
    .IO_AW   (IO_AW)
  ) dut (
    .i_Clk    (clk),
    .i_Reset_n(rst_n),
    .i_Addr   (addr),
    .i_Data   (wdata),
    .i_We     (we),
    .i_Ioreq  (ioreq),
    .o_Data   (o_data),
    .o_Leds   (o_leds),
    .o_Display(o_display),
    .i_Buttons(buttons)
  );

  // ---------------- reference model ----------------
  logic [7:0]  m_disp, m_rdata, m_snap;
  logic [3:0]  m_leds, m_deb, m_flags;
  logic        m_en;
  int unsigned m_tcnt;      // enabled clock cycles since the last clear
  logic [3:0]  m_raw[$];    // raw button samples, one per clock edge

  function automatic logic [15:0] m_timer();
    return 16'(m_tcnt / PRESCALE);
  endfunction

  task automatic model_reset();
    m_disp = 8'h00; m_rdata = 8'h00; m_snap = 8'h00;
    m_leds = 4'h0;  m_deb = 4'h0;    m_flags = 4'h0;
    m_en = 1'b1;    m_tcnt = 0;
    m_raw.delete();
    for (int i = 0; i < DEBOUNCE + 2; i++) m_raw.push_back(4'h0);
  endtask

  // Advance the model by one clock edge using the inputs currently driven.
  task automatic model_step();
    logic [3:0]  nd, rise;
    logic [15:0] tmr;
    logic        en_old, clr, clr_flags, diff;
    int          n;
    if (!rst_n) begin
      model_reset();
      return;
    end
    tmr    = m_timer();
    en_old = m_en;
    clr    = 1'b0;
    clr_flags = 1'b0;
    m_raw.push_back(buttons);
    n  = m_raw.size();
    nd = m_deb;
    // A bit flips once its two-edge-delayed raw samples have all disagreed
    // with the debounced value for DEBOUNCE edges in a row.
    for (int b = 0; b < 4; b++) begin
      diff = 1'b1;
      for (int k = 2; k <= DEBOUNCE + 1; k++)
        if (m_raw[n-1-k][b] == m_deb[b]) diff = 1'b0;
      if (diff) nd[b] = ~m_deb[b];
    end
    if (n > DEBOUNCE + 4) void'(m_raw.pop_front());
    rise = nd & ~m_deb;

    if (ioreq && !we) begin
      case (addr)
        8'h00: m_rdata = m_disp;
        8'h01: m_rdata = {4'h0, m_leds};
        8'h02: m_rdata = {4'h0, m_deb};
        8'h03: begin m_rdata = {4'h0, m_flags}; clr_flags = 1'b1; end
        8'h04: begin m_rdata = tmr[7:0]; m_snap = tmr[15:8]; end
        8'h05: m_rdata = m_snap;
        8'h06: m_rdata = {7'h00, m_en};
        default: m_rdata = 8'h00;
      endcase
    end
    if (ioreq && we) begin
      case (addr)
        8'h00: m_disp = wdata;
        8'h01: m_leds = wdata[3:0];
        8'h06: begin m_en = wdata[0]; clr = wdata[1]; end
        default: ;
      endcase
    end
    m_flags = (clr_flags ? 4'h0 : m_flags) | rise;
    if (clr) m_tcnt = 0;
    else if (en_old) m_tcnt = m_tcnt + 1;
    m_deb = nd;
  endtask

  // ---------------- checking ----------------
  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    ntests++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s/%s observed=0x%02h expected=0x%02h", phase, tag, obs, exp);
    end
  endtask

  // One clock: model advances, DUT samples, outputs compared at the falling edge.
  task automatic step();
    model_step();
    @(posedge clk);
    @(negedge clk);
    chk("o_Data",    o_data,           m_rdata);
    chk("o_Leds",    {4'h0, o_leds},   {4'h0, m_leds});
    chk("o_Display", o_display,        m_disp);
  endtask

  // ---------------- driver tasks ----------------
  task automatic bus_wr(input logic [7:0] a, input logic [7:0] d);
    addr = a; wdata = d; we = 1'b1; ioreq = 1'b1;
    step();
    we = 1'b0; ioreq = 1'b0;
  endtask

  task automatic bus_rd(input logic [7:0] a);
    addr = a; we = 1'b0; ioreq = 1'b1;
    step();
    ioreq = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int         op;
    int         r;
    logic [7:0] a;

    rst_n = 1'b0; addr = '0; wdata = '0; we = 1'b0; ioreq = 1'b0; buttons = 4'h0;
    model_reset();
    @(negedge clk);
    phase = "reset";
    repeat (2) step();
    rst_n = 1'b1;
    bus_rd(8'h06);
    chk("ctrl_after_reset", o_data, 8'h01);

    // Register access
    phase = "regs";
    bus_wr(8'h00, 8'h3C);
    chk("display_wr", o_display, 8'h3C);
    bus_wr(8'h01, 8'hFF);
    chk("leds_wr", {4'h0, o_leds}, 8'h0F);
    bus_rd(8'h01);
    chk("leds_rd", o_data, 8'h0F);
    bus_rd(8'h00);
    chk("display_rd", o_data, 8'h3C);
    addr = 8'h00; wdata = 8'hAA; we = 1'b1; ioreq = 1'b0;
    step();
    we = 1'b0;
    chk("no_ioreq_wr", o_display, 8'h3C);
    bus_wr(8'h02, 8'hFF);
    bus_rd(8'h02);
    chk("btn_ro", o_data, 8'h00);
    bus_rd(8'h07);
    chk("unmapped_07", o_data, 8'h00);
    bus_rd(8'hFF);
    chk("unmapped_ff", o_data, 8'h00);

    // Asynchronous reset mid-run
    phase = "async_reset";
    bus_wr(8'h00, 8'h5A);
    bus_rd(8'h00);
    chk("display_5a", o_data, 8'h5A);
    rst_n = 1'b0;
    #1;
    chk("rst_o_Data", o_data, 8'h00);
    chk("rst_o_Leds", {4'h0, o_leds}, 8'h00);
    chk("rst_o_Display", o_display, 8'h00);
    model_reset();
    step();
    rst_n = 1'b1;
    bus_rd(8'h06);
    chk("ctrl_after_rerst", o_data, 8'h01);

    // Debounce: bounce 1,0 then stable 1; debounced after 6 edges, seen one read later
    phase = "debounce";
    buttons[0] = 1'b1; step();
    buttons[0] = 1'b0; step();
    buttons[0] = 1'b1;
    for (int j = 1; j <= 7; j++) begin
      bus_rd(8'h02);
      chk($sformatf("btn_rd%0d", j), o_data, (j == 7) ? 8'h01 : 8'h00);
    end
    bus_rd(8'h03);
    chk("edge_first", o_data, 8'h01);
    bus_rd(8'h03);
    chk("edge_cleared", o_data, 8'h00);

    // BTN_EDGE read on the very edge bit2 goes high
    phase = "collision";
    buttons[2] = 1'b1;
    repeat (5) step();
    bus_rd(8'h03);
    chk("edge_collide", o_data, 8'h00);
    bus_rd(8'h03);
    chk("edge_set_wins", o_data, 8'h04);

    // Timer
    phase = "timer";
    bus_wr(8'h06, 8'h03);
    repeat (4 * 'h1FF) step();
    bus_rd(8'h04);
    chk("tmr_lo_1ff", o_data, 8'hFF);
    bus_rd(8'h05);
    chk("tmr_hi_1ff", o_data, 8'h01);
    bus_wr(8'h06, 8'h03);
    repeat (4 * 'h2FF + 3) step();
    bus_rd(8'h04);
    chk("tmr_lo_2ff", o_data, 8'hFF);
    step(); step();
    bus_rd(8'h05);
    chk("tmr_hi_snapshot", o_data, 8'h02);

    // Timer control: hold while disabled, clear restarts counting
    phase = "tmr_ctrl";
    bus_wr(8'h06, 8'h00);
    repeat (10) step();
    bus_rd(8'h04);
    bus_rd(8'h06);
    chk("ctrl_disabled", o_data, 8'h00);
    repeat (20) step();
    bus_rd(8'h04);
    bus_wr(8'h06, 8'h03);
    bus_rd(8'h04);
    chk("tmr_cleared", o_data, 8'h00);
    repeat (20) step();
    bus_rd(8'h04);
    chk("tmr_resumed", o_data, 8'h05);
    bus_rd(8'h06);
    chk("ctrl_enabled", o_data, 8'h01);

    // Randomized bus traffic with bouncing buttons
    phase = "random";
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 7) == 0) buttons[$urandom_range(0, 3)] ^= 1'b1;
      r = $urandom_range(0, 9);
      a = (r < 8) ? 8'(r) : 8'($urandom_range(0, 255));
      op = $urandom_range(0, 3);
      addr = a;
      wdata = 8'($urandom_range(0, 255));
      case (op)
        0:       begin ioreq = 1'b0; we = 1'($urandom_range(0, 1)); end
        3:       begin ioreq = 1'b1; we = 1'b1; end
        default: begin ioreq = 1'b1; we = 1'b0; end
      endcase
      step();
    end
    ioreq = 1'b0; we = 1'b0;

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule
